// File: rtl/serial_rx_align_if.sv
// Serial lane receiver port bundle: one serial input, parallel word output and link status.
// valid_out is a one-clock pulse with no back-pressure; data_out is valid in that cycle and held afterwards.
interface serial_rx_align_if #(
  parameter int DATA_SIZE = 8
);
  logic                 serial_in;
  logic [DATA_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 active;
  logic                 lock_error;
  logic [1:0]           state;

  modport master (
    output serial_in,
    input  data_out, valid_out, active, lock_error, state
  );

  modport slave (
    input  serial_in,
    output data_out, valid_out, active, lock_error, state
  );
endinterface

// File: rtl/serial_rx_align.sv
// Single-lane serial-to-parallel receiver: aligns to COM symbols, locks after COM_LOCK aligned COMs,
// then emits each non-COM symbol as a parallel word with a one-clock valid pulse.
module serial_rx_align #(
  parameter int                   DATA_SIZE = 8,
  parameter logic [DATA_SIZE-1:0] COM       = 8'hBC,
  parameter int                   COM_LOCK  = 4,
  parameter int                   MAX_GAP   = 16
) (
  input  logic              clk,
  input  logic              reset,
  serial_rx_align_if.slave  bus
);
  localparam int BW = (DATA_SIZE > 2) ? $clog2(DATA_SIZE) : 1;
  localparam int CW = (COM_LOCK > 0) ? $clog2(COM_LOCK + 1) : 1;
  localparam int GW = (MAX_GAP > 0) ? $clog2(MAX_GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_SIZE - 1);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    LOCKING = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  state_t               state;
  logic [DATA_SIZE-2:0] sr;
  logic [BW-1:0]        bit_cnt;
  logic [CW-1:0]        com_cnt;
  logic [GW-1:0]        gap_cnt;
  logic [DATA_SIZE-1:0] data_q;
  logic                 valid_q;
  logic                 active_q;
  logic                 lerr_q;

  logic [DATA_SIZE-1:0] w;
  logic                 boundary;
  logic                 com_hit;
  logic                 lock_done;
  logic                 gap_full;

  // The window includes the bit being sampled now, so a symbol is recognised on its LSB edge.
  assign w         = {sr, bus.serial_in};
  assign boundary  = (bit_cnt == BIT_LAST);
  assign com_hit   = (w == COM);
  assign lock_done = ((int'(com_cnt) + 1) == COM_LOCK);
  assign gap_full  = (MAX_GAP != 0) && (int'(gap_cnt) >= MAX_GAP);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      sr       <= '0;
      bit_cnt  <= '0;
      com_cnt  <= '0;
      gap_cnt  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      active_q <= 1'b0;
      lerr_q   <= 1'b0;
    end else begin
      sr      <= w[DATA_SIZE-2:0];
      valid_q <= 1'b0;
      lerr_q  <= 1'b0;
      bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;

      case (state)
        SEARCH: begin
          // Alignment can start on any edge; the matching edge becomes the new symbol phase.
          if (com_hit) begin
            bit_cnt <= '0;
            gap_cnt <= '0;
            if (COM_LOCK == 1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
            end else begin
              state   <= LOCKING;
              com_cnt <= CW'(1);
            end
          end
        end

        LOCKING: begin
          if (boundary) begin
            if (com_hit) begin
              com_cnt <= com_cnt + 1'b1;
              if (lock_done) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
                gap_cnt  <= '0;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end
        end

        ACTIVE: begin
          if (boundary) begin
            if (com_hit) begin
              gap_cnt <= '0;
            end else if (!gap_full) begin
              data_q  <= w;
              valid_q <= 1'b1;
              if (MAX_GAP != 0 || gap_cnt != '1) begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end else begin
              // Too long without an idle symbol: drop this symbol and realign from scratch.
              lerr_q   <= 1'b1;
              state    <= SEARCH;
              active_q <= 1'b0;
              com_cnt  <= '0;
              gap_cnt  <= '0;
            end
          end
        end

        default: begin
          state    <= SEARCH;
          active_q <= 1'b0;
          com_cnt  <= '0;
          gap_cnt  <= '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.valid_out  = valid_q;
  assign bus.active     = active_q;
  assign bus.lock_error = lerr_q;
  assign bus.state      = state;
endmodule

// File: tb/tb_serial_rx_align.sv
// Bench for serial_rx_align: directed scenarios with pinned literal checks, then a randomized
// bit stream checked every clock against a bit-history reference model.
module tb_serial_rx_align;
  localparam int          DS       = 8;
  localparam logic [7:0]  COM      = 8'hBC;
  localparam int          COM_LOCK = 4;
  localparam int          MAX_GAP  = 16;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  serial_rx_align_if #(.DATA_SIZE(DS)) bus();

  serial_rx_align #(
    .DATA_SIZE(DS),
    .COM      (COM),
    .COM_LOCK (COM_LOCK),
    .MAX_GAP  (MAX_GAP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Works on absolute edge numbers: symbol boundaries are edges a multiple of DS after the
  // edge where alignment was found; the window is the last DS bits of the received history.
  typedef enum int {M_SEARCH, M_LOCKING, M_ACTIVE} mode_t;
  mode_t      m_mode;
  int         m_n, m_anchor, m_seen, m_run;
  bit         hist[$];
  logic [7:0] m_data;
  logic       m_valid, m_lerr;
  logic [DS-1:0] exp_q[$];

  function automatic void model_reset();
    m_mode = M_SEARCH; m_n = 0; m_anchor = 0; m_seen = 0; m_run = 0;
    hist.delete();
    m_data = '0; m_valid = 1'b0; m_lerr = 1'b0;
    exp_q.delete();
  endfunction

  function automatic void model_step(input bit b);
    int  w;
    bit  bnd;
    m_n++;
    hist.push_back(b);
    if (hist.size() > DS) void'(hist.pop_front());
    w = 0;
    foreach (hist[i]) w = w * 2 + int'(hist[i]);
    bnd = (m_n > m_anchor) && (((m_n - m_anchor) % DS) == 0);
    m_valid = 1'b0;
    m_lerr  = 1'b0;
    case (m_mode)
      M_SEARCH: if (w == int'(COM)) begin
        m_anchor = m_n;
        m_seen   = 1;
        m_run    = 0;
        m_mode   = (m_seen >= COM_LOCK) ? M_ACTIVE : M_LOCKING;
      end
      M_LOCKING: if (bnd) begin
        if (w == int'(COM)) begin
          m_seen++;
          if (m_seen == COM_LOCK) begin m_mode = M_ACTIVE; m_run = 0; end
        end else m_mode = M_SEARCH;
      end
      M_ACTIVE: if (bnd) begin
        if (w == int'(COM)) m_run = 0;
        else if (MAX_GAP == 0 || m_run < MAX_GAP) begin
          m_data  = 8'(w);
          m_valid = 1'b1;
          m_run++;
          exp_q.push_back(8'(w));
        end else begin
          m_lerr = 1'b1;
          m_mode = M_SEARCH;
        end
      end
      default: m_mode = M_SEARCH;
    endcase
  endfunction

  // ---------------- per-cycle compare ----------------
  initial begin
    logic [31:0] want;
    model_reset();
    forever begin
      @(posedge clk);
      #1;
      if (!reset) model_reset();
      else model_step(bus.serial_in);
      check("valid_out",  32'(bus.valid_out),  32'(m_valid));
      check("data_out",   32'(bus.data_out),   32'(m_data));
      check("active",     32'(bus.active),     32'(m_mode == M_ACTIVE));
      check("lock_error", 32'(bus.lock_error), 32'(m_lerr));
      if (bus.valid_out) begin
        want = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hxxxx_xxxx;
        check("scoreboard_word", 32'(bus.data_out), want);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input bit b);
    @(negedge clk);
    bus.serial_in = b;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic after_lsb();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    reset = 1'b0;
    bus.serial_in = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic logic [7:0] rand_data();
    logic [7:0] v;
    do v = 8'($urandom_range(0, 255)); while (v == COM);
    return v;
  endfunction

  task automatic lock_link(input string tag);
    for (int k = 1; k <= COM_LOCK; k++) begin
      send_byte(COM);
      after_lsb();
      check({tag, "_active"}, 32'(bus.active), 32'(k == COM_LOCK));
      check({tag, "_novalid"}, 32'(bus.valid_out), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    logic [7:0] burst [17];
    bus.serial_in = 1'b1;

    // T1: reset held 3 clocks
    repeat (3) @(posedge clk);
    #2;
    check("t1_data", 32'(bus.data_out), 32'd0);
    check("t1_valid", 32'(bus.valid_out), 32'd0);
    check("t1_active", 32'(bus.active), 32'd0);
    check("t1_lerr", 32'(bus.lock_error), 32'd0);
    check("t1_state_search", 32'(bus.state), 32'd0);
    @(negedge clk);
    bus.serial_in = 1'b0;
    reset = 1'b1;

    // T2: junk then 4 COMs
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    lock_link("t2");

    // T3: data, COM, data
    send_byte(8'hA5);
    after_lsb();
    check("t3_valid_a5", 32'(bus.valid_out), 32'd1);
    check("t3_data_a5", 32'(bus.data_out), 32'hA5);
    send_byte(COM);
    after_lsb();
    check("t3_valid_com", 32'(bus.valid_out), 32'd0);
    check("t3_hold_a5", 32'(bus.data_out), 32'hA5);
    send_byte(8'h3C);
    after_lsb();
    check("t3_valid_3c", 32'(bus.valid_out), 32'd1);
    check("t3_data_3c", 32'(bus.data_out), 32'h3C);

    // T5: COM clears the gap, then 17 data bytes without idle
    send_byte(COM);
    for (int i = 0; i < 17; i++) burst[i] = rand_data();
    for (int i = 0; i < 16; i++) begin
      send_byte(burst[i]);
      after_lsb();
      check("t5_valid", 32'(bus.valid_out), 32'd1);
      check("t5_data", 32'(bus.data_out), 32'(burst[i]));
    end
    send_byte(burst[16]);
    after_lsb();
    check("t5_17th_novalid", 32'(bus.valid_out), 32'd0);
    check("t5_17th_lerr", 32'(bus.lock_error), 32'd1);
    check("t5_17th_inactive", 32'(bus.active), 32'd0);
    check("t5_17th_hold", 32'(bus.data_out), 32'(burst[15]));
    @(posedge clk);
    #2;
    check("t5_lerr_pulse_end", 32'(bus.lock_error), 32'd0);

    // T4: break LOCKING after 2 COMs
    reset_pulse();
    send_byte(COM);
    send_byte(COM);
    send_byte(8'h00);
    after_lsb();
    check("t4_state_search", 32'(bus.state), 32'd0);
    check("t4_inactive", 32'(bus.active), 32'd0);
    lock_link("t4");

    // T6: async reset in the middle of a symbol
    send_byte(8'h5A);
    after_lsb();
    check("t6_data_5a", 32'(bus.data_out), 32'h5A);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(posedge clk);
    #3;
    reset = 1'b0;
    bus.serial_in = 1'b0;
    #1;
    check("t6_async_data", 32'(bus.data_out), 32'd0);
    check("t6_async_active", 32'(bus.active), 32'd0);
    check("t6_async_valid", 32'(bus.valid_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    lock_link("t6");

    // Randomized stream: phase slips, idle/data mixes, long data runs, occasional reset
    repeat (30) begin
      repeat ($urandom_range(0, 7)) send_bit(1'($urandom_range(0, 1)));
      repeat ($urandom_range(3, 6)) send_byte(COM);
      repeat ($urandom_range(10, 40)) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 25) send_byte(COM);
        else if (r < 28) send_bit(1'($urandom_range(0, 1)));
        else begin
          v = rand_data();
          send_byte(v);
        end
      end
      if ($urandom_range(0, 4) == 0) repeat (18) send_byte(rand_data());
      if ($urandom_range(0, 5) == 0) reset_pulse();
    end

    repeat (4) send_byte(COM);
    repeat (4) @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
